seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 71429: master_clk cycles each digit is driven per scan slot (range 2..2^20-1).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16: all-anodes-off cycles between slots (range 1..255).
REQ-003 SHALL have parameter BLINK_DIV, default 50000000: master_clk cycles per blink half-period (range 2..2^28-1).
REQ-004 SHALL have port master_clk  in  1: the one clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port enable  in  1: level; 1 = scanning, 0 = display off.
REQ-007 SHALL have port load  in  1: single-cycle strobe capturing digits_in/dp_in into the shadow register.
REQ-008 SHALL have port digits_in  in  16: four hex nibbles; [3:0] = digit 0.
REQ-009 SHALL have port dp_in  in  4: decimal point per digit, 1 = lit.
REQ-010 SHALL have port blink_mask  in  4: 1 = digit blinks.
REQ-011 SHALL have port seg  out  7: active-low segments {g,f,e,d,c,b,a}, registered.
REQ-012 SHALL have port dp  out  1: active-low decimal point, registered.
REQ-013 SHALL have port an  out  4: active-low anodes, registered; an[i] selects digit i.
REQ-014 SHALL have port frame_start  out  1: one-cycle pulse when a DRIVE slot for digit 0 begins.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, BLANK plus 2-bit index idx.
REQ-016 IDLE SHALL transition to DRIVE with idx=0 on the first cycle enable=1.
REQ-017 In DRIVE, scan_cnt SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1 the FSM SHALL enter BLANK, idx <= idx+1 mod 4, blank_cnt <= 0.
REQ-018 In BLANK, blank_cnt SHALL count 0..BLANK_CYCLES-1, then return to DRIVE with scan_cnt <= 0.
REQ-019 enable=0 in any state SHALL force IDLE on the next edge, idx <= 0, scan_cnt and blank_cnt <= 0; enable has priority over all counter wraps.
REQ-020 load=1 SHALL copy digits_in/dp_in into the shadow register on that edge; back-to-back loads keep the last value.
REQ-021 Shadow SHALL transfer to the active register only on DRIVE entry with idx=0, so a frame never mixes old and new digits; load in the same cycle as the transfer SHALL be transferred in the next frame, not this one.
REQ-022 blink_cnt SHALL run 0..BLINK_DIV-1 whenever rst=1, independent of enable; on wrap, blink_phase SHALL toggle.
REQ-023 Outputs SHALL be registered one cycle after the state they represent: DRIVE -> an = ~(1<<idx), seg = hex decode of active nibble idx, dp = ~active_dp[idx]; IDLE/BLANK -> an=4'b1111, seg=7'h7F, dp=1.
REQ-024 In DRIVE with blink_mask[idx]=1 and blink_phase=1, an SHALL be 4'b1111 (slot timing unchanged).
REQ-025 Hex decode SHALL be standard 7-seg: 0->1000000, 1->1111001, 8->0000000, A->0001000, F->0001110 (all 16 codes defined).
REQ-026 frame_start SHALL assert for exactly one cycle, aligned with the first output cycle of digit 0's DRIVE slot.
REQ-027 Frame period SHALL be exactly 4*(SCAN_DIV+BLANK_CYCLES) cycles while enable stays 1.

Reset
REQ-028 rst=0 SHALL immediately force: state IDLE, idx 0, all counters 0, blink_phase 0, shadow and active registers 0, an=4'b1111, seg=7'h7F, dp=1, frame_start=0.
REQ-029 Reset release mid-operation SHALL resume from IDLE; scanning restarts only via REQ-016.

Verification (SCAN_DIV=4, BLANK_CYCLES=2, BLINK_DIV=16)
REQ-030 load digits_in=16'h8A10, enable=1 -> an sequence 1110,1111x2,1101,1111x2,1011,1111x2,0111,... each driven slot 4 cycles; seg 1000000, 1111001, 0001000, 0000000.
REQ-031 enable held 1 -> frame_start pulses every 24 cycles; deassert enable mid-BLANK -> an=1111 next output cycle, restart begins at digit 0.
REQ-032 load 16'h1111 mid-frame (during digit 2) -> digits 2,3 still show old values; new values appear from next frame_start.
REQ-033 blink_mask=4'b0010 -> digit 1 anode dark while blink_phase=1, toggling every 16 cycles; other digits unaffected; slot timing unchanged.
REQ-034 assert rst=0 asynchronously mid-DRIVE -> outputs at reset values without waiting for a clock edge; after release with enable=1, first driven slot is digit 0 showing 0 (seg=1000000).

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Purpose: control inputs and display outputs of the 4-digit 7-segment scanner.
// Latency: none, wires only; timing is defined by seg_scan_ctrl.
// Backpressure: none; load is a fire-and-forget strobe and outputs are free-running.
interface seg_scan_ctrl_if;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    // Controller side: drives the inputs and observes the display pins.
    modport master (
        output enable, load, digits_in, dp_in, blink_mask,
        input  seg, dp, an, frame_start
    );

    // Scanner side.
    modport slave (
        input  enable, load, digits_in, dp_in, blink_mask,
        output seg, dp, an, frame_start
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Purpose: time-multiplexed 4-digit 7-segment driver with blanking, blink and frame-coherent loads.
// Latency: outputs registered one cycle after the FSM state they show; load lands at the next frame.
// Backpressure: none; load is accepted every cycle and the latest value wins.
module seg_scan_ctrl #(
    parameter int SCAN_DIV     = 71429,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_DIV    = 50000000
) (
    input  logic            master_clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus
);
    localparam int SCW = $clog2(SCAN_DIV);
    localparam int BKW = $clog2(BLANK_CYCLES + 1);
    localparam int BLW = $clog2(BLINK_DIV);
    localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_DIV - 1);
    localparam logic [BKW-1:0] BLANK_LAST = BKW'(BLANK_CYCLES - 1);
    localparam logic [BLW-1:0] BLINK_LAST = BLW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

    state_t         state, state_nxt;
    logic [1:0]     idx, idx_nxt;
    logic [SCW-1:0] scan_cnt, scan_nxt;
    logic [BKW-1:0] blank_cnt, blank_nxt;
    logic [BLW-1:0] blink_cnt;
    logic           blink_phase;
    logic [15:0]    shadow_dig, active_dig;
    logic [3:0]     shadow_dp, active_dp;
    logic           xfer;
    logic [3:0]     an_d;
    logic [6:0]     seg_d;
    logic           dp_d;
    logic           frame_start_d;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Next state and counters; a low enable overrides every wrap.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        scan_nxt  = scan_cnt;
        blank_nxt = blank_cnt;
        if (!bus.enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            scan_nxt  = '0;
            blank_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = DRIVE;
                    idx_nxt   = '0;
                    scan_nxt  = '0;
                end
                DRIVE: begin
                    if (scan_cnt == SCAN_LAST) begin
                        state_nxt = BLANK;
                        idx_nxt   = idx + 2'd1;
                        blank_nxt = '0;
                    end else begin
                        scan_nxt = scan_cnt + SCW'(1);
                    end
                end
                BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        state_nxt = DRIVE;
                        scan_nxt  = '0;
                    end else begin
                        blank_nxt = blank_cnt + BKW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Digit 0 slot entry is the only point where a new frame's digits are adopted.
    assign xfer = (state != DRIVE) && (state_nxt == DRIVE) && (idx_nxt == 2'd0);

    // FSM state register.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            scan_cnt  <= '0;
            blank_cnt <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            scan_cnt  <= scan_nxt;
            blank_cnt <= blank_nxt;
        end
    end

    // Shadow captures loads; active copies the pre-edge shadow, so a same-cycle load waits a frame.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            shadow_dig <= '0;
            shadow_dp  <= '0;
            active_dig <= '0;
            active_dp  <= '0;
        end else begin
            if (bus.load) begin
                shadow_dig <= bus.digits_in;
                shadow_dp  <= bus.dp_in;
            end
            if (xfer) begin
                active_dig <= shadow_dig;
                active_dp  <= shadow_dp;
            end
        end
    end

    // Free-running blink timebase, independent of enable.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLW'(1);
        end
    end

    // Pin values for the current state; blink only darkens the anode, never the slot timing.
    always_comb begin
        an_d          = 4'b1111;
        seg_d         = 7'h7F;
        dp_d          = 1'b1;
        frame_start_d = 1'b0;
        if (state == DRIVE) begin
            seg_d         = hex7(active_dig[{idx, 2'b00} +: 4]);
            dp_d          = ~active_dp[idx];
            an_d          = (bus.blink_mask[idx] && blink_phase) ? 4'b1111 : ~(4'b0001 << idx);
            frame_start_d = (idx == 2'd0) && (scan_cnt == '0);
        end
    end

    // Output registers, one cycle behind the state.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            bus.an          <= 4'b1111;
            bus.seg         <= 7'h7F;
            bus.dp          <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            bus.an          <= an_d;
            bus.seg         <= seg_d;
            bus.dp          <= dp_d;
            bus.frame_start <= frame_start_d;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Purpose: checks seg_scan_ctrl against a frame-position reference model.
// Latency: compares every output one cycle after the modelled state.
// Backpressure: none; stimulus is applied every cycle.
module tb_seg_scan_ctrl;
    localparam int S     = 4;
    localparam int B     = 2;
    localparam int BD    = 16;
    localparam int SLOT  = S + B;
    localparam int FRAME = 4 * SLOT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_scan_ctrl_if bus();

    seg_scan_ctrl #(.SCAN_DIV(S), .BLANK_CYCLES(B), .BLINK_DIV(BD)) dut (
        .master_clk (clk),
        .rst        (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_fs = -1;

    logic [6:0] hex_tab [16];

    // Reference model: scanning flag plus position within the frame.
    bit          m_run;
    int          m_st;
    logic [15:0] m_sh_d, m_act_d;
    logic [3:0]  m_sh_dp, m_act_dp;
    int          m_bedges;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_st = 0; m_sh_d = '0; m_act_d = '0;
        m_sh_dp = '0; m_act_dp = '0; m_bedges = 0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        last_fs = -1;
    endtask

    task automatic model_edge();
        bit p_run, p_ph;
        int p_st, d;
        logic [15:0] p_d;
        logic [3:0] p_dp, nib;
        if (!rst) begin
            model_reset();
            return;
        end
        p_run = m_run; p_st = m_st; p_d = m_act_d; p_dp = m_act_dp;
        p_ph  = ((m_bedges / BD) % 2) == 1;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        if (p_run && (p_st % SLOT) < S) begin
            d     = p_st / SLOT;
            nib   = p_d[d*4 +: 4];
            e_seg = hex_tab[nib];
            e_dp  = ~p_dp[d];
            e_an  = (bus.blink_mask[d] && p_ph) ? 4'hF : ~(4'b0001 << d);
        end
        e_fs = p_run && (p_st == 0);
        if (!bus.enable) begin
            m_run = 0;
            last_fs = -1;
        end else if (!m_run) begin
            m_run = 1; m_st = 0;
        end else begin
            m_st = (m_st + 1) % FRAME;
        end
        if (m_run && m_st == 0) begin
            m_act_d = m_sh_d; m_act_dp = m_sh_dp;
        end
        if (bus.load) begin
            m_sh_d = bus.digits_in; m_sh_dp = bus.dp_in;
        end
        m_bedges++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk("an", 32'(bus.an), 32'(e_an));
        chk("seg", 32'(bus.seg), 32'(e_seg));
        chk("dp", 32'(bus.dp), 32'(e_dp));
        chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
        if (bus.frame_start) begin
            if (last_fs >= 0) chk("frame_period", cyc - last_fs, FRAME);
            last_fs = cyc;
        end
    endtask

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_an"}, 32'(bus.an), 32'hF);
        chk({tag, "_seg"}, 32'(bus.seg), 32'h7F);
        chk({tag, "_dp"}, 32'(bus.dp), 32'h1);
        chk({tag, "_fs"}, 32'(bus.frame_start), 32'h0);
    endtask

    // Advance until the model is at frame position lo..hi (inclusive, mod FRAME) while scanning.
    task automatic wait_pos(input string tag, input int lo, input int hi);
        bit found = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (m_run && m_st >= lo && m_st <= hi) begin
                found = 1;
                break;
            end
            tick();
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL %s observed=timeout expected=position %0d..%0d", tag, lo, hi);
        end
    endtask

    initial begin
        hex_tab[0] = 7'b1000000; hex_tab[1] = 7'b1111001; hex_tab[2] = 7'b0100100; hex_tab[3] = 7'b0110000;
        hex_tab[4] = 7'b0011001; hex_tab[5] = 7'b0010010; hex_tab[6] = 7'b0000010; hex_tab[7] = 7'b1111000;
        hex_tab[8] = 7'b0000000; hex_tab[9] = 7'b0010000; hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
        hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001; hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;
        bus.enable = 0; bus.load = 0; bus.digits_in = '0; bus.dp_in = '0; bus.blink_mask = '0;
        model_reset();

        // Reset state.
        #2 rst = 1'b0;
        #1 chk_reset_pins("reset");
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Load 8A10 and start scanning.
        bus.load = 1; bus.digits_in = 16'h8A10; bus.dp_in = 4'b0100;
        tick();
        bus.load = 0; bus.enable = 1;
        tick();
        tick();
        chk("d0_an", 32'(bus.an), 32'hE);
        chk("d0_seg", 32'(bus.seg), 32'h40);
        for (int i = 0; i < SLOT; i++) tick();
        chk("d1_an", 32'(bus.an), 32'hD);
        chk("d1_seg", 32'(bus.seg), 32'h79);
        for (int i = 0; i < 3 * FRAME; i++) tick();

        // Disable mid-BLANK, then restart from digit 0.
        wait_pos("reach_blank", SLOT + S, SLOT + S);
        bus.enable = 0;
        tick();
        chk("dis_an", 32'(bus.an), 32'hF);
        tick();
        tick();
        bus.enable = 1;
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // Load during digit 2: the rest of this frame keeps the old digits.
        wait_pos("reach_d2", 2 * SLOT, 2 * SLOT + S - 1);
        bus.load = 1; bus.digits_in = 16'h1111; bus.dp_in = 4'b1111;
        tick();
        bus.load = 0;
        for (int i = 0; i < 2 * FRAME; i++) tick();

        // Blink digit 1.
        bus.blink_mask = 4'b0010;
        for (int i = 0; i < 5 * FRAME; i++) tick();

        // Randomised traffic.
        for (int i = 0; i < 700; i++) begin
            bus.load      = ($urandom_range(0, 7) == 0);
            bus.digits_in = 16'($urandom);
            bus.dp_in     = 4'($urandom);
            bus.enable    = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 49) == 0) bus.blink_mask = 4'($urandom);
            tick();
        end
        bus.load = 0; bus.enable = 1; bus.blink_mask = '0;

        // Asynchronous reset mid-DRIVE, then restart showing zeros.
        wait_pos("reach_drive", 1, 2);
        #2 rst = 1'b0;
        #1 chk_reset_pins("async_rst");
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        tick();
        chk("post_rst_an", 32'(bus.an), 32'hE);
        chk("post_rst_seg", 32'(bus.seg), 32'h40);
        for (int i = 0; i < 2 * FRAME; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
